sdram_responder: RTL and testbench

Synthesizable SDR SDRAM device model that sits on the far side of the SDRAM controller's pin-level bus. It decodes the command bus, tracks per-bank open rows and serves single-word reads and writes from an internal block-RAM store with programmable CAS latency. It also flags protocol violations. It serves as the simulation and FPGA-loopback stand-in for the external 32-bit SDRAM, so the controller and the chipset above it can run without the physical chip.

---
 rtl/sdram_responder.sv | 178 +++++++++++++++++
 tb/tb_sdram_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDR SDRAM device model: decodes the command bus, tracks open rows per bank and serves
// single-word reads/writes from an internal store with CAS latency 2 or 3.
module sdram_responder #(
    parameter int unsigned ROW_BITS = 4,
    parameter int unsigned MIN_RCD  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_cs,
    input  logic        sd_ras,
    input  logic        sd_cas,
    input  logic        sd_we,
    input  logic [1:0]  sd_ba,
    input  logic [10:0] sd_addr,
    input  logic [3:0]  sd_dqm,
    input  logic [31:0] sd_data_in,
    output logic [31:0] sd_data_out,
    output logic        sd_data_oe,
    output logic [10:0] mode_reg,
    output logic        mode_valid,
    output logic [15:0] refresh_count,
    input  logic        err_clr,
    output logic [5:0]  err
);
    localparam int unsigned AW    = ROW_BITS + 10;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [3:0] CmdLoadMode  = 4'b0000;
    localparam logic [3:0] CmdRefresh   = 4'b0001;
    localparam logic [3:0] CmdPrecharge = 4'b0010;
    localparam logic [3:0] CmdActive    = 4'b0011;
    localparam logic [3:0] CmdWrite     = 4'b0100;
    localparam logic [3:0] CmdRead      = 4'b0101;

    logic [3:0]  bank_open_q, bank_open_d;
    logic [10:0] row_q [4];
    logic [10:0] row_d [4];
    logic [7:0]  rcd_q [4];
    logic [7:0]  rcd_d [4];
    logic [10:0] mode_reg_q, mode_reg_d;
    logic        mode_valid_q, mode_valid_d;
    logic [15:0] refresh_q, refresh_d;
    logic [5:0]  err_q, err_d;
    logic [5:0]  viol;
    logic        do_read, do_write;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q, st2_data_q, out_data_q;
    logic        rd_v_q, rd_cl3_q, st2_v_q, oe_q;

    logic [3:0]    cmd;
    logic [2:0]    cl;
    logic          mode_ok;
    logic          rcd_short;
    logic [AW-1:0] acc_addr;

    assign cmd       = {sd_cs, sd_ras, sd_cas, sd_we};
    assign cl        = mode_reg_q[6:4];
    assign mode_ok   = mode_valid_q && (cl == 3'd2 || cl == 3'd3) && (mode_reg_q[2:0] == 3'b000);
    assign rcd_short = ({24'd0, rcd_q[sd_ba]} + 32'd1) < MIN_RCD;
    assign acc_addr  = {sd_ba, row_q[sd_ba][ROW_BITS-1:0], sd_addr[7:0]};

    always_comb begin
        bank_open_d  = bank_open_q;
        mode_reg_d   = mode_reg_q;
        mode_valid_d = mode_valid_q;
        refresh_d    = refresh_q;
        viol         = 6'd0;
        do_read      = 1'b0;
        do_write     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            row_d[i] = row_q[i];
            rcd_d[i] = (rcd_q[i] == 8'hFF) ? rcd_q[i] : rcd_q[i] + 8'd1;
        end
        case (cmd)
            CmdActive: begin
                viol[1]            = bank_open_q[sd_ba];
                bank_open_d[sd_ba] = 1'b1;
                row_d[sd_ba]       = sd_addr;
                rcd_d[sd_ba]       = 8'd0;
            end
            CmdRead, CmdWrite: begin
                viol[5] = (cmd == CmdWrite) && oe_q;
                if (!mode_ok) begin
                    viol[4] = 1'b1;
                end else if (!bank_open_q[sd_ba]) begin
                    viol[0] = 1'b1;
                end else begin
                    viol[2]  = rcd_short;
                    do_read  = (cmd == CmdRead);
                    do_write = (cmd == CmdWrite);
                    if (sd_addr[10]) bank_open_d[sd_ba] = 1'b0;
                end
            end
            CmdPrecharge: begin
                if (sd_addr[10]) bank_open_d = 4'd0;
                else bank_open_d[sd_ba] = 1'b0;
            end
            CmdRefresh: begin
                if (|bank_open_q) viol[3] = 1'b1;
                else refresh_d = refresh_q + 16'd1;
            end
            CmdLoadMode: begin
                if (|bank_open_q) begin
                    viol[3] = 1'b1;
                end else begin
                    mode_reg_d   = sd_addr;
                    mode_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
        // A violation on the clearing edge still lands.
        err_d = (err_clr ? 6'd0 : err_q) | viol;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_open_q  <= 4'd0;
            mode_reg_q   <= 11'd0;
            mode_valid_q <= 1'b0;
            refresh_q    <= 16'd0;
            err_q        <= 6'd0;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= 11'd0;
                rcd_q[i] <= 8'd0;
            end
        end else begin
            bank_open_q  <= bank_open_d;
            mode_reg_q   <= mode_reg_d;
            mode_valid_q <= mode_valid_d;
            refresh_q    <= refresh_d;
            err_q        <= err_d;
            for (int i = 0; i < 4; i++) begin
                row_q[i] <= row_d[i];
                rcd_q[i] <= rcd_d[i];
            end
        end
    end

    // Store survives reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (do_write && !reset) begin
            for (int n = 0; n < 4; n++) begin
                if (!sd_dqm[n]) mem[acc_addr][8*n +: 8] <= sd_data_in[8*n +: 8];
            end
        end
        rd_data_q  <= mem[acc_addr];
        st2_data_q <= rd_data_q;
    end

    // rd stage holds store output after E; CL=3 adds st2 before the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v_q     <= 1'b0;
            rd_cl3_q   <= 1'b0;
            st2_v_q    <= 1'b0;
            oe_q       <= 1'b0;
            out_data_q <= 32'd0;
        end else begin
            rd_v_q   <= do_read;
            rd_cl3_q <= (cl == 3'd3);
            st2_v_q  <= rd_v_q && rd_cl3_q;
            oe_q     <= st2_v_q || (rd_v_q && !rd_cl3_q);
            if (st2_v_q) out_data_q <= st2_data_q;
            else if (rd_v_q && !rd_cl3_q) out_data_q <= rd_data_q;
            else out_data_q <= 32'd0;
        end
    end

    assign sd_data_out   = out_data_q;
    assign sd_data_oe    = oe_q;
    assign mode_reg      = mode_reg_q;
    assign mode_valid    = mode_valid_q;
    assign refresh_count = refresh_q;
    assign err           = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a per-cycle vector table plus hand-written
// sequences for reset-mid-read, mode-invalid reads and refresh-counter wrap.
module tb_sdram_responder;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] LMR = 4'b0000;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] RD  = 4'b0101;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd = NOP;
    logic [1:0]  sd_ba = 2'd0;
    logic [10:0] sd_addr = 11'd0;
    logic [3:0]  sd_dqm = 4'd0;
    logic [31:0] sd_data_in = 32'd0;
    logic        err_clr = 1'b0;
    logic [31:0] sd_data_out;
    logic        sd_data_oe;
    logic [10:0] mode_reg;
    logic        mode_valid;
    logic [15:0] refresh_count;
    logic [5:0]  err;

    int checks = 0;
    int errors = 0;

    sdram_responder dut (
        .clk          (clk),
        .reset        (reset),
        .sd_cs        (cmd[3]),
        .sd_ras       (cmd[2]),
        .sd_cas       (cmd[1]),
        .sd_we        (cmd[0]),
        .sd_ba        (sd_ba),
        .sd_addr      (sd_addr),
        .sd_dqm       (sd_dqm),
        .sd_data_in   (sd_data_in),
        .sd_data_out  (sd_data_out),
        .sd_data_oe   (sd_data_oe),
        .mode_reg     (mode_reg),
        .mode_valid   (mode_valid),
        .refresh_count(refresh_count),
        .err_clr      (err_clr),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [10:0] addr;
        logic [3:0]  dqm;
        logic [31:0] wdata;
        logic        clr;
        logic        exp_oe;
        logic [31:0] exp_data;
        logic [5:0]  exp_err;
        logic        exp_mv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] c, input logic [1:0] ba, input logic [10:0] a,
                       input logic [3:0] m, input logic [31:0] d, input logic clr,
                       input logic eoe, input logic [31:0] ed, input logic [5:0] ee,
                       input logic emv);
        vec_t v;
        v.cmd = c; v.ba = ba; v.addr = a; v.dqm = m; v.wdata = d; v.clr = clr;
        v.exp_oe = eoe; v.exp_data = ed; v.exp_err = ee; v.exp_mv = emv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Apply one command; returns 1 time unit after the edge that sampled it.
    task automatic issue(input logic [3:0] c, input logic [1:0] ba, input logic [10:0] a,
                         input logic [3:0] m, input logic [31:0] d, input logic clr);
        cmd = c; sd_ba = ba; sd_addr = a; sd_dqm = m; sd_data_in = d; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // cmd   ba  addr     dqm   wdata         clr  oe  data          err     mv
        add(PRE, 0, 11'h400, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  0);
        add(LMR, 0, 11'h220, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(ACT, 1, 11'h003, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(WR,  1, 11'h410, 4'h0, 32'hDEADBEEF, 0,   0,  32'h0,        6'h00,  1);
        add(ACT, 1, 11'h003, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(RD,  1, 11'h010, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   1,  32'hDEADBEEF, 6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(WR,  1, 11'h020, 4'h0, 32'h11223344, 0,   0,  32'h0,        6'h00,  1);
        add(WR,  1, 11'h020, 4'hC, 32'hAABBCCDD, 0,   0,  32'h0,        6'h00,  1);
        add(RD,  1, 11'h020, 4'hF, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   1,  32'h1122CCDD, 6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(RD,  1, 11'h010, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   1,  32'hDEADBEEF, 6'h00,  1);
        add(WR,  1, 11'h030, 4'h0, 32'h55,       0,   0,  32'h0,        6'h20,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        1,   0,  32'h0,        6'h00,  1);
        add(PRE, 0, 11'h400, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(LMR, 0, 11'h230, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(ACT, 1, 11'h003, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(WR,  1, 11'h000, 4'h0, 32'hA0A0A0A0, 0,   0,  32'h0,        6'h00,  1);
        add(WR,  1, 11'h001, 4'h0, 32'hB1B1B1B1, 0,   0,  32'h0,        6'h00,  1);
        add(RD,  1, 11'h000, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(RD,  1, 11'h001, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   1,  32'hA0A0A0A0, 6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   1,  32'hB1B1B1B1, 6'h00,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(PRE, 0, 11'h400, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(RD,  0, 11'h000, 4'h0, 32'h0,        0,   0,  32'h0,        6'h01,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        1,   0,  32'h0,        6'h00,  1);
        add(ACT, 2, 11'h005, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);
        add(ACT, 2, 11'h006, 4'h0, 32'h0,        0,   0,  32'h0,        6'h02,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        1,   0,  32'h0,        6'h00,  1);
        add(REF, 0, 11'h000, 4'h0, 32'h0,        0,   0,  32'h0,        6'h08,  1);
        add(NOP, 0, 11'h000, 4'h0, 32'h0,        1,   0,  32'h0,        6'h00,  1);
        add(PRE, 0, 11'h400, 4'h0, 32'h0,        0,   0,  32'h0,        6'h00,  1);

        repeat (2) @(posedge clk);
        #1;
        chk("reset oe", 32'(sd_data_oe), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset mode_valid", 32'(mode_valid), 32'd0);
        chk("reset mode_reg", 32'(mode_reg), 32'd0);
        chk("reset refresh", 32'(refresh_count), 32'd0);
        chk("reset data", sd_data_out, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].cmd, vecs[i].ba, vecs[i].addr, vecs[i].dqm, vecs[i].wdata,
                  vecs[i].clr);
            chk($sformatf("v%0d oe", i), 32'(sd_data_oe), 32'(vecs[i].exp_oe));
            if (vecs[i].exp_oe) chk($sformatf("v%0d data", i), sd_data_out, vecs[i].exp_data);
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d mode_valid", i), 32'(mode_valid), 32'(vecs[i].exp_mv));
            chk($sformatf("v%0d refresh", i), 32'(refresh_count), 32'd0);
        end

        // Reset while a CL=3 read is in flight; also clears a pending error.
        issue(RD, 0, 11'h000, 4'h0, 32'h0, 0);
        chk("pre-reset err", 32'(err), 32'h01);
        issue(ACT, 1, 11'h003, 4'h0, 32'h0, 0);
        issue(RD, 1, 11'h010, 4'h0, 32'h0, 0);
        issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
            chk($sformatf("rst%0d oe", k), 32'(sd_data_oe), 32'd0);
        end
        chk("rst err", 32'(err), 32'd0);
        chk("rst mode_valid", 32'(mode_valid), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
            chk($sformatf("post-rst%0d oe", k), 32'(sd_data_oe), 32'd0);
        end

        // READ before any LOAD_MODE.
        issue(RD, 1, 11'h010, 4'h0, 32'h0, 0);
        chk("no-mode err4", 32'(err[4]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
            chk($sformatf("no-mode%0d oe", k), 32'(sd_data_oe), 32'd0);
        end
        issue(NOP, 0, 11'h000, 4'h0, 32'h0, 1);
        chk("clr err", 32'(err), 32'd0);

        // Refresh counter wraps modulo 2^16.
        for (int k = 0; k < 65537; k++) issue(REF, 0, 11'h000, 4'h0, 32'h0, 0);
        issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
        chk("refresh wrap", 32'(refresh_count), 32'd1);
        chk("refresh err", 32'(err), 32'd0);

        // Store contents survive reset.
        issue(PRE, 0, 11'h400, 4'h0, 32'h0, 0);
        issue(LMR, 0, 11'h220, 4'h0, 32'h0, 0);
        issue(ACT, 1, 11'h003, 4'h0, 32'h0, 0);
        issue(RD, 1, 11'h010, 4'h0, 32'h0, 0);
        chk("reinit rd oe early", 32'(sd_data_oe), 32'd0);
        issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
        chk("reinit oe", 32'(sd_data_oe), 32'd1);
        chk("reinit data", sd_data_out, 32'hDEADBEEF);
        issue(NOP, 0, 11'h000, 4'h0, 32'h0, 0);
        chk("reinit oe drop", 32'(sd_data_oe), 32'd0);
        chk("reinit err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
